sr_regfile_sb: RTL and testbench

Parametrised register file with scoreboard for the pipelined SimpleRisc core. It provides one write port and two read ports with write-through bypass. A per-register pending bit set at issue and cleared at writeback gives the decode stage a ready signal for each operand. Optional hardwired zero register, configurable reset values, flush of all pending bits, and a registered outstanding-write count.

---
 rtl/sr_regfile_sb_if.sv | 45 ++++
 rtl/sr_regfile_sb.sv | 136 +++++++++++++
 tb/tb_sr_regfile_sb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sr_regfile_sb_if.sv
// sr_regfile_sb_if
// Bundles the read, issue, writeback and status signals of the
// SimpleRisc register file / scoreboard into one interface.
//   master : decode/issue/writeback side (drives addresses, strobes, data)
//   slave  : the register file (returns read data, ready flags, status)
// Signals:
//   rd_adr_1/2, rd_data_1/2, rd_rdy_1/2 : two combinational read ports
//   alloc_en/alloc_adr                  : mark a destination pending at issue
//   wb_en/wb_adr/wb_data                : writeback port
//   flush                               : clear every pending bit
//   alloc_err, busy_count, idle         : registered status
interface sr_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_adr_1;
    logic [ADDR_W-1:0] rd_adr_2;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic              rd_rdy_1;
    logic              rd_rdy_2;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_adr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              alloc_err;
    logic [ADDR_W:0]   busy_count;
    logic              idle;

    modport master (
        output rd_adr_1, rd_adr_2, alloc_en, alloc_adr,
               wb_en, wb_adr, wb_data, flush,
        input  rd_data_1, rd_data_2, rd_rdy_1, rd_rdy_2,
               alloc_err, busy_count, idle
    );

    modport slave (
        input  rd_adr_1, rd_adr_2, alloc_en, alloc_adr,
               wb_en, wb_adr, wb_data, flush,
        output rd_data_1, rd_data_2, rd_rdy_1, rd_rdy_2,
               alloc_err, busy_count, idle
    );
endinterface

// File: rtl/sr_regfile_sb.sv
// sr_regfile_sb
// Register file with per-register scoreboard for the pipelined SimpleRisc
// core: one write port, two bypassed combinational read ports, a pending
// bit per register (set at issue, cleared at writeback), optional
// hardwired zero register, flush of all pending bits, and registered
// alloc-error / outstanding-write count / idle status.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high
//   bus   : sr_regfile_sb_if.slave (reads, alloc, writeback, flush, status)
module sr_regfile_sb #(
    parameter int              DATA_W       = 32,
    parameter int              NUM_REGS     = 16,
    parameter int              ADDR_W       = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] RESET_VAL    = 32'h1,
    parameter int              SP_IDX       = 2,
    parameter logic [DATA_W-1:0] SP_RESET_VAL = 32'h5,
    parameter bit              ZERO_REG     = 1'b0
) (
    input logic           clk,
    input logic           reset,
    sr_regfile_sb_if.slave bus
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                allocErr_q;
    logic                allocErr_d;
    logic [ADDR_W:0]     busyCount_q;
    logic [ADDR_W:0]     busyCount_d;
    logic                idle_q;

    logic                wbWrite;
    logic                allocTake;

    logic [ADDR_W-1:0]   rdAdr  [2];
    logic [DATA_W-1:0]   rdData [2];
    logic                rdRdy  [2];

    // Zero register wins over the stack-pointer reset value if both
    // land on index 0.
    function automatic logic [DATA_W-1:0] initValue(input int idx);
        if (ZERO_REG && idx == 0)
            return '0;
        else if (idx == SP_IDX)
            return SP_RESET_VAL;
        else
            return RESET_VAL;
    endfunction

    // Writes and allocs aimed at a hardwired zero register are dropped
    // here so that register 0 can never become pending.
    always_comb begin
        wbWrite   = bus.wb_en && !(ZERO_REG && bus.wb_adr == '0);
        allocTake = bus.alloc_en && !bus.flush
                    && !(ZERO_REG && bus.alloc_adr == '0);
    end

    // Writeback clears first, then alloc sets, so a same-cycle alloc and
    // writeback to one register leaves it pending for the new producer.
    // Flush overrides both.
    always_comb begin
        pending_d = pending_q;
        if (wbWrite)
            pending_d[bus.wb_adr] = 1'b0;
        if (allocTake)
            pending_d[bus.alloc_adr] = 1'b1;
        if (bus.flush)
            pending_d = '0;
    end

    // An alloc is only an error when the register stays pending from an
    // earlier issue, i.e. it is not retired by a writeback this cycle.
    always_comb begin
        allocErr_d = allocTake && pending_q[bus.alloc_adr]
                     && !(wbWrite && bus.wb_adr == bus.alloc_adr);
    end

    always_comb begin
        busyCount_d = '0;
        for (int i = 0; i < NUM_REGS; i++)
            busyCount_d = busyCount_d + (ADDR_W+1)'(pending_d[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= initValue(i);
        end else if (wbWrite) begin
            regs_q[bus.wb_adr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q   <= '0;
            allocErr_q  <= 1'b0;
            busyCount_q <= '0;
            idle_q      <= 1'b1;
        end else begin
            pending_q   <= pending_d;
            allocErr_q  <= allocErr_d;
            busyCount_q <= busyCount_d;
            idle_q      <= (busyCount_d == '0);
        end
    end

    // Read ports: zero register, then writeback bypass, then the array.
    // The bypass uses the raw wb strobe; with ZERO_REG the r0 case is
    // already resolved by the first branch.
    always_comb begin
        rdAdr[0] = bus.rd_adr_1;
        rdAdr[1] = bus.rd_adr_2;
        for (int p = 0; p < 2; p++) begin
            rdData[p] = regs_q[rdAdr[p]];
            rdRdy[p]  = ~pending_q[rdAdr[p]];
            if (ZERO_REG && rdAdr[p] == '0) begin
                rdData[p] = '0;
                rdRdy[p]  = 1'b1;
            end else if (bus.wb_en && bus.wb_adr == rdAdr[p]) begin
                rdData[p] = bus.wb_data;
                rdRdy[p]  = 1'b1;
            end
        end
    end

    assign bus.rd_data_1  = rdData[0];
    assign bus.rd_data_2  = rdData[1];
    assign bus.rd_rdy_1   = rdRdy[0];
    assign bus.rd_rdy_2   = rdRdy[1];
    assign bus.alloc_err  = allocErr_q;
    assign bus.busy_count = busyCount_q;
    assign bus.idle       = idle_q;

endmodule

// File: tb/tb_sr_regfile_sb.sv
// tb_sr_regfile_sb
// Drives two register-file instances (ZERO_REG=0 and ZERO_REG=1) with the
// same directed and random traffic and compares them against a reference
// model of the architectural registers and pending set.
module tb_sr_regfile_sb;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]  rdAdr1, rdAdr2, allocAdr, wbAdr;
    logic        allocEn, wbEn, flushIn;
    logic [31:0] wbData;

    int checks = 0;
    int failures = 0;

    // Reference state, one slot per instance (1 = zero-register variant)
    logic [31:0] mReg  [2][16];
    bit          mPend [2][16];
    bit          mErr  [2];
    int          mBusy [2];

    sr_regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
    sr_regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

    assign bus0.rd_adr_1 = rdAdr1;   assign bus1.rd_adr_1 = rdAdr1;
    assign bus0.rd_adr_2 = rdAdr2;   assign bus1.rd_adr_2 = rdAdr2;
    assign bus0.alloc_en = allocEn;  assign bus1.alloc_en = allocEn;
    assign bus0.alloc_adr = allocAdr; assign bus1.alloc_adr = allocAdr;
    assign bus0.wb_en = wbEn;        assign bus1.wb_en = wbEn;
    assign bus0.wb_adr = wbAdr;      assign bus1.wb_adr = wbAdr;
    assign bus0.wb_data = wbData;    assign bus1.wb_data = wbData;
    assign bus0.flush = flushIn;     assign bus1.flush = flushIn;

    sr_regfile_sb #(.ZERO_REG(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    sr_regfile_sb #(.ZERO_REG(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void modelReset(input int d);
        for (int i = 0; i < 16; i++) begin
            mReg[d][i]  = (i == 2) ? 32'h5 : 32'h1;
            mPend[d][i] = 1'b0;
        end
        if (d == 1) mReg[d][0] = 32'h0;
        mErr[d]  = 1'b0;
        mBusy[d] = 0;
    endfunction

    function automatic void modelRead(input int d, input int adr,
                                      output logic [31:0] data, output logic rdy);
        if (d == 1 && adr == 0) begin
            data = 32'h0; rdy = 1'b1;
        end else if (wbEn && int'(wbAdr) == adr) begin
            data = wbData; rdy = 1'b1;
        end else begin
            data = mReg[d][adr]; rdy = !mPend[d][adr];
        end
    endfunction

    function automatic void modelEdge(input int d);
        bit nextPend [16];
        bit wbHits, allocHits;
        wbHits    = wbEn && !(d == 1 && wbAdr == 0);
        allocHits = allocEn && !(d == 1 && allocAdr == 0);
        nextPend  = mPend[d];
        mErr[d]   = 1'b0;
        if (wbHits) begin
            mReg[d][wbAdr]  = wbData;
            nextPend[wbAdr] = 1'b0;
        end
        if (flushIn) begin
            foreach (nextPend[i]) nextPend[i] = 1'b0;
        end else if (allocHits) begin
            if (mPend[d][allocAdr] && !(wbHits && wbAdr == allocAdr))
                mErr[d] = 1'b1;
            nextPend[allocAdr] = 1'b1;
        end
        mPend[d] = nextPend;
        mBusy[d] = 0;
        foreach (nextPend[i]) mBusy[d] += int'(nextPend[i]);
    endfunction

    task automatic checkReads(input int d, input logic [31:0] data1, input logic [31:0] data2,
                              input logic rdy1, input logic rdy2);
        logic [31:0] e1, e2;
        logic r1, r2;
        modelRead(d, int'(rdAdr1), e1, r1);
        modelRead(d, int'(rdAdr2), e2, r2);
        checkOutput($sformatf("d%0d_rd_data_1 adr=%0d", d, rdAdr1), data1, e1);
        checkOutput($sformatf("d%0d_rd_data_2 adr=%0d", d, rdAdr2), data2, e2);
        checkOutput($sformatf("d%0d_rd_rdy_1 adr=%0d", d, rdAdr1), 32'(rdy1), 32'(r1));
        checkOutput($sformatf("d%0d_rd_rdy_2 adr=%0d", d, rdAdr2), 32'(rdy2), 32'(r2));
    endtask

    task automatic checkStatus(input int d, input logic err, input logic [4:0] busy, input logic idl);
        checkOutput($sformatf("d%0d_alloc_err", d), 32'(err), 32'(mErr[d]));
        checkOutput($sformatf("d%0d_busy_count", d), 32'(busy), 32'(mBusy[d]));
        checkOutput($sformatf("d%0d_idle", d), 32'(idl), 32'(mBusy[d] == 0));
    endtask

    task automatic checkAll();
        checkReads(0, bus0.rd_data_1, bus0.rd_data_2, bus0.rd_rdy_1, bus0.rd_rdy_2);
        checkReads(1, bus1.rd_data_1, bus1.rd_data_2, bus1.rd_rdy_1, bus1.rd_rdy_2);
    endtask

    // One clock cycle: drive at the falling edge, check combinational reads,
    // advance the model on the rising edge, check registered status after it.
    task automatic applyStimulus(input bit ae, input int aa, input bit we, input int wa,
                                 input logic [31:0] wd, input bit fl, input int r1, input int r2);
        allocEn = ae; allocAdr = 4'(aa);
        wbEn = we; wbAdr = 4'(wa); wbData = wd;
        flushIn = fl; rdAdr1 = 4'(r1); rdAdr2 = 4'(r2);
        #1;
        checkAll();
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
        checkStatus(0, bus0.alloc_err, bus0.busy_count, bus0.idle);
        checkStatus(1, bus1.alloc_err, bus1.busy_count, bus1.idle);
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the asynchronous return to reset
    // values, and holds it across an edge with traffic that must be ignored.
    task automatic pulseReset(input int r1);
        allocEn = 1'b0; wbEn = 1'b0; flushIn = 1'b0;
        rdAdr1 = 4'(r1); rdAdr2 = 4'd2;
        #2 reset = 1'b1;
        modelReset(0);
        modelReset(1);
        #1;
        checkAll();
        checkStatus(0, bus0.alloc_err, bus0.busy_count, bus0.idle);
        checkStatus(1, bus1.alloc_err, bus1.busy_count, bus1.idle);
        allocEn = 1'b1; allocAdr = 4'(r1);
        wbEn = 1'b1; wbAdr = 4'(r1); wbData = $urandom;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wbEn = 1'b0; allocEn = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        allocEn = 1'b0; allocAdr = '0; wbEn = 1'b0; wbAdr = '0; wbData = '0;
        flushIn = 1'b0; rdAdr1 = '0; rdAdr2 = '0;
        modelReset(0);
        modelReset(1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values
        rdAdr1 = 4'd2; rdAdr2 = 4'd7;
        #1;
        checkOutput("tp_reset_sp", bus0.rd_data_1, 32'h5);
        checkOutput("tp_reset_r7", bus0.rd_data_2, 32'h1);
        checkOutput("tp_reset_idle", 32'(bus0.idle), 32'h1);
        checkOutput("tp_reset_busy", 32'(bus0.busy_count), 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 2, 7);

        // Alloc r3, stall, writeback with bypass, then array read
        applyStimulus(1, 3, 0, 0, 0, 0, 3, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 2);
        applyStimulus(0, 0, 1, 3, 32'hDEADBEEF, 0, 3, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
        checkOutput("tp_r3_written", bus0.rd_data_1, 32'hDEADBEEF);

        // Double alloc error, then alloc + writeback on the same register
        applyStimulus(1, 4, 0, 0, 0, 0, 4, 1);
        applyStimulus(1, 4, 0, 0, 0, 0, 4, 1);
        checkOutput("tp_alloc_err", 32'(bus0.alloc_err), 32'h1);
        applyStimulus(1, 4, 1, 4, 32'h10, 0, 4, 1);
        checkOutput("tp_alloc_wb_noerr", 32'(bus0.alloc_err), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4, 1);
        checkOutput("tp_r4_pending", 32'(bus0.rd_rdy_1), 32'h0);

        // Fill, then flush overriding an alloc
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 5);
        applyStimulus(1, 5, 0, 0, 0, 0, 1, 5);
        applyStimulus(1, 9, 0, 0, 0, 0, 9, 5);
        applyStimulus(1, 6, 1, 9, 32'h99, 1, 6, 9);
        checkOutput("tp_flush_busy", 32'(bus0.busy_count), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 6, 4);

        // Register 0 write/alloc
        applyStimulus(0, 0, 1, 0, 32'h55, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("tp_zero_reg", bus1.rd_data_1, 32'h0);

        // Reset mid-operation
        applyStimulus(1, 8, 0, 0, 0, 0, 8, 3);
        pulseReset(8);
        applyStimulus(0, 0, 0, 0, 0, 0, 8, 3);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0)
                pulseReset(int'($urandom_range(0, 15)));
            else
                applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                              bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
                              $urandom, bit'($urandom_range(0, 24) == 0),
                              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
